fp_add_align: RTL and testbench

Front-end stage of the 8-bit minifloat adder/subtractor.
- Accepts two packed operands and an add/sub command.
- Orders the operands by magnitude and aligns the smaller mantissa with a sticky bit.
- Presents a registered (a, b, c_in) triple to the 8-bit carry-lookahead adder, together with the result exponent and sign.
- Two-stage pipeline with valid/ready flow control; throughput of one operation per cycle.

---
 rtl/fp8_pkg.sv | 24 ++
 rtl/align_shifter.sv | 26 ++
 rtl/fp_add_align.sv | 129 ++++++++++++
 tb/tb_fp_add_align.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared constants and field layout for the 8-bit minifloat datapath.
package fp8_pkg;

    localparam int unsigned EXP_W   = 4;
    localparam int unsigned FRAC_W  = 3;
    localparam int unsigned MANT_W  = 8;
    localparam int unsigned FP_W    = 1 + EXP_W + FRAC_W;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned GUARD_W = MANT_W - 1 - FRAC_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp8_t;

    // exp == 0 encodes zero: no hidden bit and the fraction is ignored.
    function automatic logic [MANT_W-1:0] fp8_mant(input fp8_t x);
        logic nz;
        nz = (x.exp != '0);
        return {nz, (nz ? x.frac : {FRAC_W{1'b0}}), {GUARD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/align_shifter.sv
// Right-shifts the smaller mantissa by the exponent difference, folding every
// bit shifted out into the LSB as a sticky bit.
module align_shifter
    import fp8_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [3:0]        shamt_i,
    output logic [MANT_W-1:0] mant_o
);

    logic [MANT_W-1:0] lost_mask;

    // Shift with sticky; shifts of MANT_W or more leave only the sticky bit.
    always_comb begin
        lost_mask = '0;
        mant_o    = '0;
        if (int'(shamt_i) >= int'(MANT_W)) begin
            mant_o[0] = |mant_i;
        end else begin
            lost_mask = ~({MANT_W{1'b1}} << shamt_i);
            mant_o    = mant_i >> shamt_i;
            mant_o[0] = mant_o[0] | (|(mant_i & lost_mask));
        end
    end

endmodule

// File: rtl/fp_add_align.sv
// Front end of the minifloat adder: magnitude ordering, swap, alignment and
// presentation of the (a, b, c_in) triple to the carry-lookahead adder.
module fp_add_align
    import fp8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   op_a,
    input  logic [FP_W-1:0]   op_b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] add_a,
    output logic [MANT_W-1:0] add_b,
    output logic              add_cin,
    output logic [EXP_W-1:0]  exp_out,
    output logic              sign_out,
    output logic              eff_sub
);

    fp8_t              a, b, l, s;
    logic              sb_e, swap, tie;
    logic              s1_eff_sub_d, s1_sign_d;
    logic [EXP_W-1:0]  s1_d_d;

    logic              s1_valid_q, s1_sign_q, s1_eff_sub_q;
    logic [MANT_W-1:0] s1_ml_q, s1_ms_q;
    logic [EXP_W-1:0]  s1_d_q, s1_exp_q;

    logic              out_valid_q, add_cin_q, sign_q, eff_sub_q;
    logic [MANT_W-1:0] add_a_q, add_b_q, sh, add_b_d;
    logic [EXP_W-1:0]  exp_q;

    logic              out_adv, s1_adv, in_fire;

    assign a = fp8_t'(op_a);
    assign b = fp8_t'(op_b);

    // Handshake: each stage moves when the one after it can take its entry.
    assign out_adv  = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || out_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    // Order operands by magnitude and derive the result sign.
    always_comb begin
        sb_e         = b.sign ^ sub;
        s1_eff_sub_d = a.sign ^ sb_e;
        swap         = {b.exp, b.frac} > {a.exp, a.frac};
        tie          = {b.exp, b.frac} == {a.exp, a.frac};
        l            = swap ? b : a;
        s            = swap ? a : b;
        s1_d_d       = l.exp - s.exp;
        if (tie) begin
            // Exact cancellation yields +0; equal-magnitude addition keeps A's sign.
            s1_sign_d = s1_eff_sub_d ? 1'b0 : a.sign;
        end else begin
            s1_sign_d = swap ? sb_e : a.sign;
        end
    end

    // Stage 1 register: ordered mantissas, exponent difference and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_ml_q      <= '0;
            s1_ms_q      <= '0;
            s1_d_q       <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_eff_sub_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_fire) begin
                s1_ml_q      <= fp8_mant(l);
                s1_ms_q      <= fp8_mant(s);
                s1_d_q       <= s1_d_d;
                s1_exp_q     <= l.exp;
                s1_sign_q    <= s1_sign_d;
                s1_eff_sub_q <= s1_eff_sub_d;
            end
        end
    end

    align_shifter u_align_shifter (
        .mant_i  (s1_ms_q),
        .shamt_i (s1_d_q),
        .mant_o  (sh)
    );

    // Subtraction feeds the adder ~b with carry-in 1 (two's complement).
    always_comb begin
        add_b_d = s1_eff_sub_q ? ~sh : sh;
    end

    // Output register: held stable while the adder stage stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
        end else if (out_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                add_a_q   <= s1_ml_q;
                add_b_q   <= add_b_d;
                add_cin_q <= s1_eff_sub_q;
                exp_q     <= s1_exp_q;
                sign_q    <= s1_sign_q;
                eff_sub_q <= s1_eff_sub_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign exp_out   = exp_q;
    assign sign_out  = sign_q;
    assign eff_sub   = eff_sub_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed vectors, backpressure,
// reset flush and randomized traffic against a plain-arithmetic model.
module tb_fp_add_align;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, sub, out_valid, out_ready;
    logic [7:0] op_a, op_b, add_a, add_b;
    logic       add_cin, sign_out, eff_sub;
    logic [3:0] exp_out;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic        last_acc;
    logic [22:0] pending;
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    fp_add_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .exp_out   (exp_out),
        .sign_out  (sign_out),
        .eff_sub   (eff_sub)
    );

    // Expected {add_a, add_b, add_cin, exp_out, sign_out, eff_sub} from the number rules.
    function automatic logic [22:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ma, mb, ea, eb, mant_a, mant_b, ml, msm, el, es, d, sh;
        bit sa, sbe, esub, swap, sign;
        ma = a[6:0];  mb = b[6:0];
        ea = a[6:3];  eb = b[6:3];
        sa = a[7];    sbe = b[7] ^ s;
        esub = sa ^ sbe;
        swap = mb > ma;
        mant_a = (ea == 0) ? 0 : (8 + a[2:0]) * 16;
        mant_b = (eb == 0) ? 0 : (8 + b[2:0]) * 16;
        if (swap) begin ml = mant_b; msm = mant_a; el = eb; es = ea; end
        else      begin ml = mant_a; msm = mant_b; el = ea; es = eb; end
        if (ma == mb) sign = esub ? 1'b0 : sa;
        else          sign = swap ? sbe : sa;
        d = el - es;
        if (d >= 8) begin
            sh = (msm != 0) ? 1 : 0;
        end else begin
            sh = msm / (1 << d);
            if ((msm % (1 << d)) != 0) sh = sh | 1;
        end
        if (esub) sh = 255 - sh;
        return {ml[7:0], sh[7:0], esub, el[3:0], sign, esub};
    endfunction

    function automatic logic [22:0] obs();
        return {add_a, add_b, add_cin, exp_out, sign_out, eff_sub};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // One clock: sample at negedge, retire outputs, log acceptances, then step.
    task automatic tick();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("result", 32'(obs()), 32'(exp_q.pop_front()));
                pops++;
            end
        end
        if (last_acc) exp_q.push_back(pending);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [22:0] e);
        op_a = a; op_b = b; sub = s; pending = e; in_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [22:0] e);
        int n = 0;
        drive(a, b, s, e);
        do begin tick(); n++; end while (!last_acc && n < 50);
        chk("accept_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0]  bp_a[4] = '{8'h38, 8'h41, 8'hC9, 8'h2F};
    logic [7:0]  bp_b[4] = '{8'h40, 8'h3A, 8'h30, 8'hB8};
    logic        bp_s[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [22:0] snap;
    int          idx, pops0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; sub = 1'b0; pending = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outputs", 32'(obs()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors from hand-derived values.
        send(8'h38, 8'h40, 1'b0, {8'h80, 8'h40, 1'b0, 4'd8, 1'b0, 1'b0});
        send(8'h40, 8'h38, 1'b1, {8'h80, 8'hBF, 1'b1, 4'd8, 1'b0, 1'b1});
        send(8'h30, 8'h09, 1'b0, {8'h80, 8'h05, 1'b0, 4'd6, 1'b0, 1'b0});
        send(8'h50, 8'h08, 1'b0, {8'h80, 8'h01, 1'b0, 4'd10, 1'b0, 1'b0});
        send(8'h38, 8'h38, 1'b1, {8'h80, 8'h7F, 1'b1, 4'd7, 1'b0, 1'b1});
        send(8'hB8, 8'h40, 1'b0, {8'h80, 8'hBF, 1'b1, 4'd8, 1'b0, 1'b1});
        send(8'h00, 8'h38, 1'b0, {8'h80, 8'h00, 1'b0, 4'd7, 1'b0, 1'b0});
        drain();

        // Backpressure: four back-to-back operations against a stalled output.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(bp_a[idx], bp_b[idx], bp_s[idx], model(bp_a[idx], bp_b[idx], bp_s[idx]));
            tick();
            if (last_acc) idx++;
            if (c == 1) snap = obs();
            if (c >= 2) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'(obs()), 32'(snap));
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        pops0 = pops;
        for (int c = 0; c < 4; c++) begin
            if (idx < 4) drive(bp_a[idx], bp_b[idx], bp_s[idx], model(bp_a[idx], bp_b[idx], bp_s[idx]));
            else in_valid = 1'b0;
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_burst", 32'(pops - pops0), 32'd4);
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(8'h45, 8'h33, 1'b0, model(8'h45, 8'h33, 1'b0));
        send(8'h21, 8'hA7, 1'b1, model(8'h21, 8'hA7, 1'b1));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(8'h5A, 8'h4C, 1'b1, model(8'h5A, 8'h4C, 1'b1));
        tick();
        chk("rst_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        chk("latency_c1", 32'(out_valid), 32'd0);
        tick();
        chk("latency_c2", 32'(out_valid), 32'd1);
        drain();

        // Randomized traffic with random gaps and random backpressure.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = 1'($urandom);
                drive(ra, rb, rs, model(ra, rb, rs));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
